// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified IF/DM memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side (IF, DM) and memory-side signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = unified_mem_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = unified_mem_arbiter_pkg::DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
  );
endinterface

// File: rtl/unified_mem_arbiter_pick.sv
// Winner select between IF and DM; DM has priority until IF has lost
// STARVE_LIMIT contested rounds in a row.
module mem_arb_pick
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant,
  output owner_e winner
);
  localparam int CNT_W = cnt_w(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             force_if;

  always_comb begin
    force_if = (STARVE_LIMIT != 0) && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    winner   = (dm_req && !(if_req && force_if)) ? OWN_DM : OWN_IF;

    starve_cnt_d = starve_cnt_q;
    if (grant) begin
      if (winner == OWN_IF)
        starve_cnt_d = '0;
      else if (if_req && starve_cnt_q != CNT_W'(STARVE_LIMIT))
        starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the IF and DM stages:
// arbitrate, issue one strobe, wait MEM_LATENCY, pulse ready to the owner.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);
  localparam int WCNT_W = cnt_w(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            winner;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant;

  assign grant = (state_q == IDLE) && (bus.if_req || bus.dm_req);

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wcnt_d      = wcnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    unique case (state_q)
      IDLE: if (grant) begin
        owner_d = winner;
        state_d = ISSUE;
        if (winner == OWN_DM) begin
          mem_addr_d  = bus.dm_addr;
          mem_we_d    = bus.dm_we;
          mem_wdata_d = bus.dm_wdata;
        end else begin
          mem_addr_d  = bus.if_addr;
          mem_we_d    = 1'b0;
        end
      end
      ISSUE: begin
        wcnt_d  = WCNT_W'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: if (wcnt_q == '0) begin
        // mem_rdata is valid only in this cycle; stores leave dm_rdata alone.
        if (owner_q == OWN_IF)  if_rdata_d = bus.mem_rdata;
        else if (!mem_we_q)     dm_rdata_d = bus.mem_rdata;
        state_d = DONE;
      end else begin
        wcnt_d = wcnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      wcnt_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wcnt_q      <= wcnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = (state_q == DONE) && (owner_q == OWN_IF);
  assign bus.dm_ready  = (state_q == DONE) && (owner_q == OWN_DM);
  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_dm  = bus.dm_req & ~bus.dm_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Random IF/DM traffic against a transaction-level model of the arbiter; a
// negedge monitor pops expected issues/completions and compares.
module tb_unified_mem_arbiter;
  localparam int L     = 2;
  localparam int SL    = 2;
  localparam int N_CYC = 3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          cyc;
    bit          dm;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] if_rd;
    logic [31:0] dm_rd;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  exp_t        iss_q[$];
  exp_t        rdy_q[$];
  resp_t       resp_q[$];
  logic [31:0] mem_dut[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          if_act = 0, dm_act = 0, dm_we_c = 0;
  logic [31:0] if_addr_c = 0, dm_addr_c = 0, dm_wdata_c = 0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00A00093;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h100 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory: capture strobes at negedge, return read data exactly L cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.mem_en === 1'b1) begin
        if (bus.mem_we) mem_dut[bus.mem_addr] = bus.mem_wdata;
        else resp_q.push_back('{due: cyc + L,
                                data: mem_dut.exists(bus.mem_addr) ? mem_dut[bus.mem_addr]
                                                                   : init_word(bus.mem_addr)});
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    bit   exp_ifr, exp_dmr;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_mem_en",    bus.mem_en,    0);
        chk("rst_mem_we",    bus.mem_we,    0);
        chk("rst_mem_addr",  bus.mem_addr,  0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_ready",  bus.if_ready,  0);
        chk("rst_dm_ready",  bus.dm_ready,  0);
        chk("rst_if_rdata",  bus.if_rdata,  0);
        chk("rst_dm_rdata",  bus.dm_rdata,  0);
        chk("rst_stall_if",  bus.stall_if,  if_act);
        chk("rst_stall_dm",  bus.stall_dm,  dm_act);
      end else begin
        exp_ifr = rdy_q.size() > 0 && rdy_q[0].cyc == cyc && !rdy_q[0].dm;
        exp_dmr = rdy_q.size() > 0 && rdy_q[0].cyc == cyc &&  rdy_q[0].dm;
        chk("stall_if", bus.stall_if, if_act && !exp_ifr);
        chk("stall_dm", bus.stall_dm, dm_act && !exp_dmr);

        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
          e = iss_q.pop_front();
          chk("mem_en",   bus.mem_en,   1);
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_we",   bus.mem_we,   e.we);
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
        end else begin
          chk("mem_en_idle", bus.mem_en, 0);
        end

        if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
          e = rdy_q.pop_front();
          chk("if_ready", bus.if_ready, !e.dm);
          chk("dm_ready", bus.dm_ready,  e.dm);
          chk("if_rdata", bus.if_rdata, e.if_rd);
          chk("dm_rdata", bus.dm_rdata, e.dm_rd);
        end else begin
          chk("if_ready_idle", bus.if_ready, 0);
          chk("dm_ready_idle", bus.dm_ready, 0);
        end
      end
    end
  end

  // Stimulus plus reference model.
  initial begin
    bit          sif, sdm, rst_done, win_dm, last_if_grant;
    int          free_at, starve, rst_rel, grant_cyc;
    logic [31:0] last_if, last_dm, a;
    exp_t        e;

    sif = 0; sdm = 0; rst_done = 0; last_if_grant = 0;
    free_at = 0; starve = 0; rst_rel = -1; grant_cyc = -100;
    last_if = 0; last_dm = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0;

    for (int i = 0; i < N_CYC + 40; i++) begin
      @(negedge clk);
      sif = bus.if_ready;
      sdm = bus.dm_ready;
      @(posedge clk);
      #1;
      cyc++;

      // Reset control: initial reset, then one abort of an IF access in WAIT.
      if (cyc == 6 || cyc == rst_rel) begin
        reset = 1'b1;
        free_at = cyc; starve = 0; last_if = 0; last_dm = 0;
        sif = 0; sdm = 0;
      end else if (!rst_done && cyc > 1500 && last_if_grant && cyc == grant_cyc + 2) begin
        reset = 1'b0;
        rst_done = 1; rst_rel = cyc + 3;
        iss_q.delete(); rdy_q.delete(); resp_q.delete();
      end

      if (resp_q.size() > 0 && resp_q[0].due == cyc) bus.mem_rdata = resp_q.pop_front().data;
      else bus.mem_rdata = $urandom;

      if (cyc < 6) begin
        if_act = 1'($urandom_range(0, 1)); if_addr_c = rand_addr();
        dm_act = 1'($urandom_range(0, 1)); dm_addr_c = rand_addr();
        dm_we_c = 1'($urandom_range(0, 1)); dm_wdata_c = $urandom;
      end else begin
        if (sif) if_act = (cyc < N_CYC) && ($urandom_range(0, 9) < 7);
        else if (!if_act && cyc < N_CYC) if_act = ($urandom_range(0, 9) < 3);
        if (if_act && (sif || !bus.if_req)) if_addr_c = rand_addr();
        if (sdm) dm_act = (cyc < N_CYC) && ($urandom_range(0, 9) < 7);
        else if (!dm_act && cyc < N_CYC) dm_act = ($urandom_range(0, 9) < 3);
        if (dm_act && (sdm || !bus.dm_req)) begin
          dm_addr_c = rand_addr(); dm_we_c = 1'($urandom_range(0, 1)); dm_wdata_c = $urandom;
        end
      end
      bus.if_req = if_act; bus.if_addr = if_addr_c;
      bus.dm_req = dm_act; bus.dm_addr = dm_addr_c;
      bus.dm_we = dm_we_c; bus.dm_wdata = dm_wdata_c;

      // One access at a time: issue next cycle, ready L+2 later, next arbitration L+3 later.
      if (reset && cyc >= free_at && (if_act || dm_act)) begin
        win_dm = dm_act && !(if_act && SL != 0 && starve == SL);
        a = win_dm ? dm_addr_c : if_addr_c;
        e.dm = win_dm; e.addr = a; e.we = win_dm && dm_we_c; e.wdata = dm_wdata_c;
        if (win_dm) begin
          if (if_act) starve = (starve < SL) ? starve + 1 : SL;
          if (dm_we_c) ref_mem[a] = dm_wdata_c;
          else last_dm = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        end else begin
          starve = 0;
          last_if = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        end
        e.if_rd = last_if; e.dm_rd = last_dm;
        e.cyc = cyc + 1;     iss_q.push_back(e);
        e.cyc = cyc + L + 2; rdy_q.push_back(e);
        free_at = cyc + L + 3;
        grant_cyc = cyc; last_if_grant = !win_dm;
      end
    end

    @(negedge clk);
    chk("pending_issues", iss_q.size(), 0);
    chk("pending_readies", rdy_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch stage (IF port) and the memory stage (DM port) of the 5-stage RISC-V pipeline.
- Arbitrates between the two ports, sequences each access (issue, wait, complete) and returns a one-cycle ready pulse to the winning requester.
- Drives the stall_if and stall_dm signals that freeze the pipeline while a port waits.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range >=1.
- STARVE_LIMIT, 4, consecutive contested DM wins before IF is forced to win; 0 = strict DM priority.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held high until if_ready.
- if_addr  in  ADDR_W  IF address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; holds its value until the next IF completion.
- if_ready  out  1  one-cycle IF completion pulse.
- dm_req  in  1  DM request; held high until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  DM address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; updated on load completion only.
- dm_ready  out  1  one-cycle DM completion pulse.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  if_req & ~if_ready (combinational).
- stall_dm  out  1  dm_req & ~dm_ready (combinational).

Behaviour:
- Reset (reset==0, asynchronous):
  - state = IDLE, owner = IF, starve_cnt = 0, wait counter = 0.
  - mem_en, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, if_rdata and dm_rdata all = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise pick a winner. Only one request → that port. Both → DM, unless STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT, in which case IF.
  - Register owner and the mem_addr, mem_we (IF: 0) and mem_wdata values; go to ISSUE.
- ISSUE: mem_en = 1 for exactly this cycle; load the wait counter with MEM_LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the wait counter each cycle.
  - In the cycle the counter reads 0, mem_rdata is valid. At the end of that cycle, capture it into the owner's rdata (loads and IF only) and go to DONE.
  - mem_en = 0 throughout WAIT.
- DONE: owner's ready = 1 for this cycle only; go to IDLE. A requester that sees ready drops or renews its request at the same edge.
- Timing:
  - Request-to-ready latency from IDLE = MEM_LATENCY+2 cycles.
  - Issue-to-issue spacing = MEM_LATENCY+3 cycles, because DONE is always followed by an IDLE arbitration cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when DM wins while if_req is high.
  - Clears when IF wins.
  - Unchanged on an uncontested DM win.
- mem_addr, mem_we and mem_wdata hold their values until the next grant. mem_we is meaningless outside mem_en.
- Store completion: dm_ready pulses; dm_rdata is unchanged.
- A request dropped mid-access is a protocol violation. The access still completes and the ready pulse is still issued.
- Reset asserted in ISSUE, WAIT or DONE: the in-flight access is abandoned, no ready pulse follows release, and arbitration restarts in IDLE.
- There is no address decode and no alignment check; the memory handles both.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - owner encoding (OWN_IF=1'b0, OWN_DM=1'b1);
  - default ADDR_W and DATA_W.
- One sub-module, mem_arb_pick: combinational winner select from if_req, dm_req and starve_cnt, plus the saturating starvation counter register.
- The FSM, wait counter and output registers stay in the top module.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=2, request raised in cycle c0):
1. Hold reset low, toggle inputs → all outputs 0, stall_if/stall_dm follow the reqs; release → first grant occurs in IDLE.
2. IF alone, if_addr=0x100, memory returns 0x00A00093 in c3:
   - mem_en=1 in c1 only, mem_addr=0x100, mem_we=0;
   - if_ready=1 in c4, if_rdata=0x00A00093;
   - stall_if=1 in c0–c3.
3. if_req with if_addr=0x104 together with a DM store (dm_addr=0x200, dm_wdata=0xDEADBEEF) in c0:
   - DM wins: mem_we=1, mem_addr=0x200 in c1; dm_ready in c4; dm_rdata unchanged;
   - IF then issues in c6 and completes with if_ready in c9.
4. dm_req renewed back-to-back (loads 0x300/0x304/0x308) with if_req held:
   - grant order DM, DM, IF, DM;
   - starve_cnt reaches 2, then clears on the IF grant.
5. Reset pulled low in c2 (WAIT) of an IF access → outputs 0 immediately; no if_ready after release; the held if_req is regranted from IDLE.
6. DM load from 0x400 with mem_rdata=0x12345678 → dm_ready in c4, dm_rdata=0x12345678, if_rdata untouched.
